// File: rtl/square_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : square_share_arbiter_if
// Brief    : Request/response bundle between clients and square_share_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface square_share_arbiter_if #(
    parameter int N    = 4,
    parameter int NREQ = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_num;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*N-1:0]    rsp_result;
    logic [IDW-1:0]    rsp_id;

    modport slave (
        input  req_valid, req_num, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id
    );

    modport master (
        output req_valid, req_num, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id
    );
endinterface
`default_nettype wire

// File: rtl/square_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : square_share_arbiter
// Brief    : Round-robin arbiter sharing one N-cycle shift-add squarer among
//            NREQ requesters. Define SQUARE_EARLY_EXIT_EN to stop the
//            iteration as soon as no set operand bits remain.
// Revision : 1.0 - initial release
// ============================================================================
module square_share_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    square_share_arbiter_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_op;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_result;
    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_last_grant;

    logic [IDW-1:0]   w_grant;
    logic             w_grant_any;
    logic             w_accept;
    logic [NREQ-1:0]  w_ready;
    logic [N-1:0]     w_op_sel;
    logic [2*N-1:0]   w_addend;
    logic [2*N-1:0]   w_acc_nxt;
    logic [CW:0]      w_cnt_p1;
    logic             w_last_step;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant     = '0;
        w_grant_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_grant_any && bus.req_valid[IDW'(idx)]) begin
                w_grant     = IDW'(idx);
                w_grant_any = 1'b1;
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_grant_any;

    // Ready is gated by rst_n so it reads zero while reset is held.
    always_comb begin
        w_ready = '0;
        if (rst_n && w_accept) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_op_sel = bus.req_num[int'(w_grant)*N +: N];

    // One shift-add step: add op<<cnt when bit cnt of the operand is set.
    assign w_addend  = r_op[r_cnt] ? ({{N{1'b0}}, r_op} << r_cnt) : '0;
    assign w_acc_nxt = r_acc + w_addend;
    assign w_cnt_p1  = {1'b0, r_cnt} + (CW+1)'(1);

`ifdef SQUARE_EARLY_EXIT_EN
    assign w_last_step = (r_cnt == CW'(N-1)) || ((r_op >> w_cnt_p1) == '0);
`else
    assign w_last_step = (r_cnt == CW'(N-1));
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_grant_any)   w_state_nxt = S_CALC;
            S_CALC: if (w_last_step)   w_state_nxt = S_RESP;
            S_RESP: if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_id         <= '0;
            r_last_grant <= IDW'(NREQ-1);
        end else begin
            if (w_accept) begin
                r_op         <= w_op_sel;
                r_id         <= w_grant;
                r_acc        <= '0;
                r_cnt        <= '0;
                r_last_grant <= w_grant;
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + CW'(1);
                if (w_last_step) begin
                    r_result <= w_acc_nxt;
                end
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_result = r_result;
    assign bus.rsp_id     = r_id;

endmodule
`default_nettype wire
